// File: rtl/ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage of the 16-bit pipelined MIPS core. Selects operand
//            B, evaluates the ALU (add/sub/and/or/slt/sll/srl), computes the
//            branch target and zero flag, selects the destination register and
//            forwards gated control to EX/MEM. A shift-add multiplier runs over
//            DATA_W cycles and stalls the front end while it works.
// Ports    : clk, rst            - falling-edge clock, async active-high reset
//            i_flush             - kill the instruction currently in EX
//            i_pc_plus_two, i_read_data_1, i_read_data_2, i_immediate
//                                - ID/EX datapath values
//            i_alu_src, i_alu_op, i_reg_dest, i_rt, i_rd
//                                - ID/EX datapath control
//            i_mem_read, i_mem_write, i_branch, i_mem_to_reg, i_reg_write
//                                - ID/EX control forwarded to EX/MEM
//            o_alu_result, o_store_data, o_dest_reg, o_branch_target, o_zero
//            o_mem_read, o_mem_write, o_branch, o_mem_to_reg, o_reg_write
//            o_stall             - hold PC, IF/ID and ID/EX
//            o_mul_busy          - multiplier iterating
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_pc_plus_two,
  input  logic [DATA_W-1:0] i_read_data_1,
  input  logic [DATA_W-1:0] i_read_data_2,
  input  logic [DATA_W-1:0] i_immediate,
  input  logic              i_alu_src,
  input  logic [1:0]        i_alu_op,
  input  logic              i_reg_dest,
  input  logic [REG_W-1:0]  i_rt,
  input  logic [REG_W-1:0]  i_rd,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_branch,
  input  logic              i_mem_to_reg,
  input  logic              i_reg_write,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_store_data,
  output logic [REG_W-1:0]  o_dest_reg,
  output logic [DATA_W-1:0] o_branch_target,
  output logic              o_zero,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_branch,
  output logic              o_mem_to_reg,
  output logic              o_reg_write,
  output logic              o_stall,
  output logic              o_mul_busy
);

  localparam int                c_cnt_w    = $clog2(DATA_W);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [DATA_W-1:0]   r_product;
  logic [c_cnt_w-1:0]  r_count;

  logic [DATA_W-1:0]   w_op_b;
  logic [2:0]          w_funct;
  logic                w_is_mul;
  logic                w_start;
  logic [DATA_W-1:0]   w_alu;

  // ---------------------------------------------------------------- ALU
  assign w_op_b   = i_alu_src ? i_immediate : i_read_data_2;
  assign w_funct  = i_immediate[2:0];
  assign w_is_mul = (i_alu_op == 2'b10) && (w_funct == 3'b101);

  always_comb begin
    w_alu = '0;
    case (i_alu_op)
      2'b00: w_alu = i_read_data_1 + w_op_b;
      2'b01: w_alu = i_read_data_1 - w_op_b;
      2'b11: w_alu = i_read_data_1 & w_op_b;
      default: begin
        case (w_funct)
          3'b000: w_alu = i_read_data_1 + w_op_b;
          3'b001: w_alu = i_read_data_1 - w_op_b;
          3'b010: w_alu = i_read_data_1 & w_op_b;
          3'b011: w_alu = i_read_data_1 | w_op_b;
          3'b100: w_alu = {{(DATA_W-1){1'b0}},
                           ($signed(i_read_data_1) < $signed(w_op_b))};
          3'b110: w_alu = i_read_data_1 << w_op_b[3:0];
          3'b111: w_alu = i_read_data_1 >> w_op_b[3:0];
          // mul: the real result only appears from the multiplier in DONE
          default: w_alu = '0;
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------- multiplier
  // A start is suppressed by a coincident flush: the instruction is dead.
  assign w_start = (r_state == S_IDLE) && w_is_mul && !i_flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (i_flush)                     w_state_nxt = S_IDLE;
        else if (r_count == c_cnt_last)  w_state_nxt = S_DONE;
      end
      // The pipeline advances on the edge leaving DONE, so the mul never
      // gets re-seen from IDLE.
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
      r_count   <= '0;
    end else if (w_start) begin
      r_mcand   <= i_read_data_1;
      r_mplier  <= w_op_b;
      r_product <= '0;
      r_count   <= '0;
    end else if (r_state == S_BUSY && !i_flush) begin
      if (r_mplier[0]) r_product <= r_product + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  // ------------------------------------------------------------- outputs
  assign o_stall    = !rst && (w_start || (r_state == S_BUSY));
  assign o_mul_busy = (r_state == S_BUSY);

  assign o_alu_result    = (r_state == S_DONE) ? r_product : w_alu;
  assign o_zero          = (o_alu_result == '0);
  assign o_store_data    = i_read_data_2;
  assign o_dest_reg      = i_reg_dest ? i_rd : i_rt;
  assign o_branch_target = i_pc_plus_two + {i_immediate[DATA_W-2:0], 1'b0};

  // A stall sends a bubble; mem_to_reg is harmless without reg_write so it
  // is only cleared by a flush.
  assign o_mem_read   = i_mem_read   & ~(i_flush | o_stall);
  assign o_mem_write  = i_mem_write  & ~(i_flush | o_stall);
  assign o_branch     = i_branch     & ~(i_flush | o_stall);
  assign o_reg_write  = i_reg_write  & ~(i_flush | o_stall);
  assign o_mem_to_reg = i_mem_to_reg & ~i_flush;

endmodule
`default_nettype wire
